audio_mixer_sd_stereo: RTL and testbench
========================================

// Module: audio_mixer_sd_stereo
// PURPOSE
//  Parametrised successor of the mono beeper+AY mixer/DAC. Mixes NCH unsigned PCM sources
//  (AY/TurboSound, Covox, SpecDrum...) with per-channel gain and L/R routing, adds the
//  EAR/SPK/MIC beeper level, saturates, then drives two first-order sigma-delta DAC outputs.
//  Sits between the sound sources and the stereo audio pins. Runs entirely on clkdac.
// PARAMETERS
//  NCH = 4   number of PCM input channels (1..8)
//  IW  = 8   bits per channel sample, unsigned
//  GW  = 4   bits per channel gain; gain code 2^(GW-1) = unity
//  OW  = 10  DAC input width; mix results are saturated to this width
// PORTS
//  clkdac     in   1         mixer/DAC clock; everything registered on its rising edge
//  reset      in   1         synchronous, active-high
//  ch_data    in   NCH*IW    channel samples, ch k at [k*IW +: IW]
//  ch_gain    in   NCH*GW    channel gains, ch k at [k*GW +: GW]
//  ch_pan     in   2*NCH     ch k: bit 2k routes to left, bit 2k+1 routes to right
//  ear,spk,mic in  1 each    beeper levels
//  mix_l      out  OW        last saturated left mix (held between frames)
//  mix_r      out  OW        last saturated right mix
//  mix_valid  out  1         1-cycle pulse when mix_l/mix_r update
//  audio_l    out  1         left sigma-delta bitstream
//  audio_r    out  1         right sigma-delta bitstream
// BEHAVIOUR
//  Reset (sync, any state): seq -> S_LATCH, accumulators 0, mix_l/mix_r 0, mix_valid 0,
//   audio_l/audio_r 0, both DAC integrators = 1<<(OW-1).
//  Frame sequencer, free-running, NCH+2 cycles per frame:
//   S_LATCH : snapshot ch_data, ch_gain, ch_pan, {ear,spk,mic}; clear acc_l/acc_r; idx=0.
//   S_ACC   : one channel per cycle; p = (data[idx]*gain[idx]) >> (GW-1);
//             acc_l += p if pan bit 2*idx, acc_r += p if pan bit 2*idx+1; idx++;
//             leave after idx==NCH-1.
//   S_CLIP  : add beeper level b to both accs; saturate each to 2^OW-1; write mix_l/mix_r;
//             pulse mix_valid; -> S_LATCH.
//  Beeper table {ear,spk,mic} 000..111 -> 17,36,184,192,22,48,244,255 (8-bit, zero-ext).
//  Accumulator width IW+GW+clog2(NCH+1)+1; no intermediate overflow possible.
//  Gain 0 or both pan bits 0 => channel contributes nothing. Input changes outside S_LATCH
//   are ignored until the next frame. Latency: input at S_LATCH -> mix_valid NCH+1 cycles later.
//  DAC (per side, every clkdac cycle, independent of sequencer):
//   sum = {1'b0,integ[OW-1:0]} + {1'b0,mix}; integ <= sum; audio <= sum[OW] (carry).
//   Ones density = mix / 2^OW; mix=0 -> constant 0; mix=2^OW-1 -> 1 except 1 in 2^OW.
// CONFIGURATION
//  AUDIO_MIXER_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on
//   reset, steps every clkdac); in S_CLIP lfsr[1:0] is added to each acc before saturation.
//  Undefined: no LFSR logic, no dither term; results are bit-exact per the rules above.
// STRUCTURE
//  Package audio_mix_pkg: state encoding (S_LATCH/S_ACC/S_CLIP), beeper level table,
//   LFSR seed/taps constants, clog2 function.
//  One sub-module sd_dac1 #(OW) (clkdac, reset, din, dout), instantiated twice (L, R).
// TESTING
//  1 reset: assert reset 3 cycles mid-S_ACC -> all outputs 0, next mix_valid exactly NCH+2
//    cycles after release.
//  2 routing: NCH=4, ch0=0x80 gain 8 pan 01, others gain 0, beeper 000 -> mix_l=145, mix_r=17.
//  3 saturation: all ch 0xFF gain 15 pan 11, beeper 111 -> mix_l=mix_r=1023.
//  4 gain/pan: ch2=0x40 gain 4 pan 10 -> mix_r=32+17=49, mix_l=17; change ch2 during S_ACC ->
//    result unchanged until next frame.
//  5 DAC density: hold mix=256 (OW=10) -> exactly 256 ones on audio_l per 1024-cycle window;
//    mix=0 -> audio constant 0.
//  6 dither (macro on): constant inputs -> mix varies by at most +3 across frames, never
//    exceeds 1023; macro off -> mix constant.

Source files
------------

// File: rtl/audio_mix_pkg.sv
// Shared constants for the stereo mixer: sequencer encoding, beeper levels,
// dither LFSR constants and a constant-safe clog2.
package audio_mix_pkg;

   localparam logic [1:0] S_LATCH = 2'd0;
   localparam logic [1:0] S_ACC   = 2'd1;
   localparam logic [1:0] S_CLIP  = 2'd2;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [7:0] beep_level(input logic [2:0] sel);
      logic [7:0] lvl;
      case (sel)
         3'd0:    lvl = 8'd17;
         3'd1:    lvl = 8'd36;
         3'd2:    lvl = 8'd184;
         3'd3:    lvl = 8'd192;
         3'd4:    lvl = 8'd22;
         3'd5:    lvl = 8'd48;
         3'd6:    lvl = 8'd244;
         default: lvl = 8'd255;
      endcase
      return lvl;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sd_dac1.sv
// First-order sigma-delta DAC: the carry out of a free-running OW-bit
// phase accumulator gives a ones density of din / 2^OW.
module sd_dac1 #(
   parameter int OW = 10
) (
   input  logic          clkdac,
   input  logic          reset,
   input  logic [OW-1:0] din,
   output logic          dout
);

   logic [OW-1:0] integ_q;
   logic          dout_q;
   logic [OW:0]   sum;

   assign sum  = {1'b0, integ_q} + {1'b0, din};
   assign dout = dout_q;

   always_ff @(posedge clkdac) begin
      if (reset) begin
         integ_q <= {1'b1, {(OW-1){1'b0}}};
         dout_q  <= 1'b0;
      end else begin
         integ_q <= sum[OW-1:0];
         dout_q  <= sum[OW];
      end
   end

endmodule

// File: rtl/audio_mixer_sd_stereo.sv
// NCH-channel gain/pan mixer with beeper level and saturation, feeding two
// sigma-delta DACs. Define AUDIO_MIXER_DITHER_EN to add 2-bit LFSR dither.
module audio_mixer_sd_stereo
   import audio_mix_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = 8,
   parameter int GW  = 4,
   parameter int OW  = 10
) (
   input  logic              clkdac,
   input  logic              reset,
   input  logic [NCH*IW-1:0] ch_data,
   input  logic [NCH*GW-1:0] ch_gain,
   input  logic [2*NCH-1:0]  ch_pan,
   input  logic              ear,
   input  logic              spk,
   input  logic              mic,
   output logic [OW-1:0]     mix_l,
   output logic [OW-1:0]     mix_r,
   output logic              mix_valid,
   output logic              audio_l,
   output logic              audio_r,
   output logic [1:0]        dbg_state_o
);

   localparam int AW  = IW + GW + clog2(NCH + 1) + 1;
   localparam int IXW = (NCH > 1) ? clog2(NCH) : 1;
   localparam logic [AW-1:0] MAXV = AW'((1 << OW) - 1);

   // Handshake: mix_valid is a one-cycle strobe, no ready; mix_l/mix_r hold until the next strobe.
   logic [1:0]        state_q, state_d;
   logic [IXW-1:0]    idx_q, idx_d;
   logic [NCH*IW-1:0] data_q, data_d;
   logic [NCH*GW-1:0] gain_q, gain_d;
   logic [2*NCH-1:0]  pan_q, pan_d;
   logic [2:0]        beep_q, beep_d;
   logic [AW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [OW-1:0]     mix_l_q, mix_l_d, mix_r_q, mix_r_d;
   logic              valid_q, valid_d;

   logic [IW-1:0]     d_arr [NCH];
   logic [GW-1:0]     g_arr [NCH];
   logic              pl_arr [NCH];
   logic              pr_arr [NCH];
   logic [IW+GW-1:0]  prod;
   logic [AW-1:0]     p;
   logic [AW-1:0]     dith;
   logic [AW-1:0]     sum_l, sum_r;

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         d_arr[k]  = data_q[k*IW +: IW];
         g_arr[k]  = gain_q[k*GW +: GW];
         pl_arr[k] = pan_q[2*k];
         pr_arr[k] = pan_q[2*k+1];
      end
   end

   assign prod = {{GW{1'b0}}, d_arr[idx_q]} * {{IW{1'b0}}, g_arr[idx_q]};
   assign p    = AW'(prod >> (GW - 1));

`ifdef AUDIO_MIXER_DITHER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clkdac) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign dith = AW'(lfsr_q[1:0]);
`else
   assign dith = '0;
`endif

   assign sum_l = acc_l_q + AW'(beep_level(beep_q)) + dith;
   assign sum_r = acc_r_q + AW'(beep_level(beep_q)) + dith;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      gain_d  = gain_q;
      pan_d   = pan_q;
      beep_d  = beep_q;
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      mix_l_d = mix_l_q;
      mix_r_d = mix_r_q;
      valid_d = 1'b0;
      case (state_q)
         S_LATCH: begin
            data_d  = ch_data;
            gain_d  = ch_gain;
            pan_d   = ch_pan;
            beep_d  = {ear, spk, mic};
            acc_l_d = '0;
            acc_r_d = '0;
            idx_d   = '0;
            state_d = S_ACC;
         end
         S_ACC: begin
            if (pl_arr[idx_q]) acc_l_d = acc_l_q + p;
            if (pr_arr[idx_q]) acc_r_d = acc_r_q + p;
            idx_d = idx_q + 1'b1;
            if (idx_q == IXW'(NCH - 1)) state_d = S_CLIP;
         end
         S_CLIP: begin
            mix_l_d = (sum_l > MAXV) ? '1 : sum_l[OW-1:0];
            mix_r_d = (sum_r > MAXV) ? '1 : sum_r[OW-1:0];
            valid_d = 1'b1;
            state_d = S_LATCH;
         end
         default: state_d = S_LATCH;
      endcase
   end

   always_ff @(posedge clkdac) begin
      if (reset) begin
         state_q <= S_LATCH;
         idx_q   <= '0;
         data_q  <= '0;
         gain_q  <= '0;
         pan_q   <= '0;
         beep_q  <= '0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         mix_l_q <= '0;
         mix_r_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         gain_q  <= gain_d;
         pan_q   <= pan_d;
         beep_q  <= beep_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         mix_l_q <= mix_l_d;
         mix_r_q <= mix_r_d;
         valid_q <= valid_d;
      end
   end

   assign mix_l       = mix_l_q;
   assign mix_r       = mix_r_q;
   assign mix_valid   = valid_q;
   assign dbg_state_o = state_q;

   sd_dac1 #(.OW(OW)) u_dac_l (
      .clkdac (clkdac),
      .reset  (reset),
      .din    (mix_l_q),
      .dout   (audio_l)
   );

   sd_dac1 #(.OW(OW)) u_dac_r (
      .clkdac (clkdac),
      .reset  (reset),
      .din    (mix_r_q),
      .dout   (audio_r)
   );

endmodule

// File: tb/tb_audio_mixer_sd_stereo.sv
// Bench for audio_mixer_sd_stereo (default build, dither off): randomized
// frames checked against an arithmetic mixing model, plus reset and DAC density.
module tb_audio_mixer_sd_stereo;
   import audio_mix_pkg::*;

   localparam int NCH = 4;
   localparam int IW  = 8;
   localparam int GW  = 4;
   localparam int OW  = 10;
   localparam int MAXMIX = (1 << OW) - 1;

   // ---------------- clock / reset ----------------
   logic              clkdac = 1'b0;
   logic              reset  = 1'b1;
   logic [NCH*IW-1:0] ch_data = '0;
   logic [NCH*GW-1:0] ch_gain = '0;
   logic [2*NCH-1:0]  ch_pan  = '0;
   logic              ear = 1'b0, spk = 1'b0, mic = 1'b0;
   logic [OW-1:0]     mix_l, mix_r;
   logic              mix_valid, audio_l, audio_r;
   logic [1:0]        dbg_state;

   always #5 clkdac = ~clkdac;

   audio_mixer_sd_stereo #(.NCH(NCH), .IW(IW), .GW(GW), .OW(OW)) dut (
      .clkdac      (clkdac),
      .reset       (reset),
      .ch_data     (ch_data),
      .ch_gain     (ch_gain),
      .ch_pan      (ch_pan),
      .ear         (ear),
      .spk         (spk),
      .mic         (mic),
      .mix_l       (mix_l),
      .mix_r       (mix_r),
      .mix_valid   (mix_valid),
      .audio_l     (audio_l),
      .audio_r     (audio_r),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_pass = 0;
   bit quiet_chk = 1'b0;
   int beep_tab [8] = '{17, 36, 184, 192, 22, 48, 244, 255};
   logic [2*OW-1:0] exp_q [$];

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Mixing rules in plain integer arithmetic: gain code 8 is unity.
   function automatic void model(input logic [NCH*IW-1:0] d, input logic [NCH*GW-1:0] g,
                                 input logic [2*NCH-1:0] pn, input logic [2:0] b,
                                 output int el, output int er);
      int sl, sr, contrib;
      sl = beep_tab[b];
      sr = beep_tab[b];
      for (int k = 0; k < NCH; k++) begin
         contrib = (int'(d[k*IW +: IW]) * int'(g[k*GW +: GW])) / 8;
         if (pn[2*k])   sl += contrib;
         if (pn[2*k+1]) sr += contrib;
      end
      el = (sl > MAXMIX) ? MAXMIX : sl;
      er = (sr > MAXMIX) ? MAXMIX : sr;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [NCH*IW-1:0] d, input logic [NCH*GW-1:0] g,
                        input logic [2*NCH-1:0] pn, input logic [2:0] b);
      ch_data = d;
      ch_gain = g;
      ch_pan  = pn;
      ear = b[2];
      spk = b[1];
      mic = b[0];
   endtask

   task automatic wait_valid(input int start, output int cyc);
      cyc = start;
      do begin
         @(negedge clkdac);
         cyc++;
         if (quiet_chk) check("dac_quiet", int'(audio_l | audio_r), 0);
      end while (!mix_valid && cyc < 40);
   endtask

   // Called at the negedge of an S_LATCH cycle; returns at the next one.
   task automatic frame(input logic [NCH*IW-1:0] d, input logic [NCH*GW-1:0] g,
                        input logic [2*NCH-1:0] pn, input logic [2:0] b,
                        input bit scramble, input string tag);
      int el, er, cyc, start;
      logic [2*OW-1:0] e;
      drive(d, g, pn, b);
      model(d, g, pn, b, el, er);
      exp_q.push_back({el[OW-1:0], er[OW-1:0]});
      start = 0;
      if (scramble) begin
         repeat (2) @(negedge clkdac);
         start = 2;
         drive(32'($urandom), 16'($urandom), 8'($urandom), 3'($urandom));
      end
      wait_valid(start, cyc);
      check({tag, "_latency"}, cyc, NCH + 2);
      e = exp_q.pop_front();
      check({tag, "_mix_l"}, int'(mix_l), int'(e[2*OW-1:OW]));
      check({tag, "_mix_r"}, int'(mix_r), int'(e[OW-1:0]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mix_l"},   int'(mix_l), 0);
      check({tag, "_mix_r"},   int'(mix_r), 0);
      check({tag, "_valid"},   int'(mix_valid), 0);
      check({tag, "_audio_l"}, int'(audio_l), 0);
      check({tag, "_audio_r"}, int'(audio_r), 0);
      check({tag, "_state"},   int'(dbg_state), int'(S_LATCH));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ones_l, ones_r;

      reset = 1'b1;
      repeat (3) @(negedge clkdac);
      check_reset_outputs("init_rst");
      reset = 1'b0;

      // ch0 = 0x80 unity gain routed left only, beeper 000
      quiet_chk = 1'b1;
      frame(32'h0000_0080, 16'h0008, 8'h01, 3'b000, 1'b0, "route");
      quiet_chk = 1'b0;

      frame({NCH{8'hFF}}, {NCH{4'hF}}, {NCH{2'b11}}, 3'b111, 1'b0, "sat");

      // ch2 = 0x40 half gain routed right; inputs scrambled mid-accumulation
      frame(32'h0040_0000, 16'h0400, 8'h20, 3'b000, 1'b1, "gainpan");
      frame(32'h0040_0000, 16'h0400, 8'h20, 3'b000, 1'b0, "gainpan2");

      for (int i = 0; i < 24; i++) begin
         frame(32'($urandom), 16'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), "rand");
      end

      // reset asserted for three cycles in the middle of S_ACC
      repeat (2) @(negedge clkdac);
      reset = 1'b1;
      repeat (3) @(negedge clkdac);
      check_reset_outputs("mid_rst");
      reset = 1'b0;
      quiet_chk = 1'b1;
      frame(32'($urandom), 16'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, "post_rst");
      quiet_chk = 1'b0;

      // 239 + beeper 17 = 256 on the left, 17 on the right, held for many frames
      frame(32'h0000_00EF, 16'h0008, 8'h01, 3'b000, 1'b0, "dac_set");
      repeat (3) @(negedge clkdac);
      ones_l = 0;
      ones_r = 0;
      for (int i = 0; i < (1 << OW); i++) begin
         @(negedge clkdac);
         ones_l += int'(audio_l);
         ones_r += int'(audio_r);
      end
      check("dac_density_l", ones_l, 256);
      check("dac_density_r", ones_r, 17);

      // resync to a frame boundary, then confirm the held mix stays constant
      begin
         int cyc;
         wait_valid(0, cyc);
      end
      frame(32'h0000_00EF, 16'h0008, 8'h01, 3'b000, 1'b0, "steady");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
